// File: rtl/sparse_stream_decompressor.sv
// rtl/sparse_stream_decompressor.sv - bitmap-compressed / raw byte stream to dense lane groups
// Memory words land in a circular byte buffer; one group is expanded from its head per cycle.
module sparse_stream_decompressor #(
  parameter int MEM_BYTES = 16,
  parameter int LANES     = 8,
  parameter int CNT_W     = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   raw_mode,
  input  logic [CNT_W-1:0]       group_count,
  input  logic [CNT_W-1:0]       word_count,
  output logic                   mem_req,
  input  logic [MEM_BYTES*8-1:0] mem_data,
  input  logic                   mem_data_valid,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*8-1:0]     out_data,
  output logic [LANES-1:0]       out_mask,
  output logic                   done,
  output logic                   err
);

  localparam int MASK_BYTES = LANES / 8;
  localparam int WIN_BYTES  = MASK_BYTES + LANES;
  localparam int BUF_BYTES  = 2 * MEM_BYTES + WIN_BYTES;
  localparam int IDX_W      = $clog2(BUF_BYTES);
  localparam int LVL_W      = $clog2(BUF_BYTES + 1);

  typedef logic [IDX_W-1:0] idx_t;
  typedef logic [LVL_W-1:0] lvl_t;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FINISH} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  function automatic idx_t wrap_add(idx_t p, int n);
    int s;
    s = int'(p) + n;
    if (s >= BUF_BYTES) s = s - BUF_BYTES;
    return idx_t'(s);
  endfunction

  state_t             state_q, state_d;
  logic               raw_q, raw_d;
  logic [CNT_W-1:0]   groups_tgt_q, groups_tgt_d;
  logic [CNT_W-1:0]   words_tgt_q, words_tgt_d;
  logic [CNT_W-1:0]   groups_sent_q, groups_sent_d;
  logic [CNT_W-1:0]   words_fetched_q, words_fetched_d;
  logic [7:0]         buf_q [BUF_BYTES];
  logic [7:0]         buf_d [BUF_BYTES];
  idx_t               head_q, head_d;
  idx_t               tail_q, tail_d;
  lvl_t               level_q, level_d;
  logic               out_valid_q, out_valid_d;
  logic [LANES*8-1:0] out_data_q, out_data_d;
  logic [LANES-1:0]   out_mask_q, out_mask_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  logic [7:0]         win [WIN_BYTES];
  logic [LANES-1:0]   head_mask;
  lvl_t               rank [LANES];
  lvl_t               pop_cnt;
  lvl_t               need;
  lvl_t               free_bytes;
  logic [LANES*8-1:0] dense;
  logic [LANES-1:0]   dense_mask;
  logic               push, pop, last_xfer, starve;

  always_comb begin : window
    for (int j = 0; j < WIN_BYTES; j++) begin
      win[j] = buf_q[wrap_add(head_q, j)];
    end
  end

  // rank[i] = number of set mask bits below lane i, i.e. which payload byte lane i takes
  always_comb begin : expand
    head_mask  = '0;
    pop_cnt    = '0;
    dense      = '0;
    dense_mask = '0;
    for (int i = 0; i < LANES; i++) begin
      head_mask[i] = win[i / 8][i % 8];
    end
    for (int i = 0; i < LANES; i++) begin
      rank[i] = pop_cnt;
      pop_cnt = pop_cnt + lvl_t'(head_mask[i]);
    end
    need = raw_q ? lvl_t'(LANES) : lvl_t'(MASK_BYTES) + pop_cnt;
    for (int i = 0; i < LANES; i++) begin
      if (raw_q) begin
        dense[8*i +: 8] = win[i];
        dense_mask[i]   = 1'b1;
      end else if (head_mask[i]) begin
        dense_mask[i] = 1'b1;
        for (int k = 0; k < LANES; k++) begin
          if (rank[i] == lvl_t'(k)) dense[8*i +: 8] = win[MASK_BYTES + k];
        end
      end
    end
  end

  assign free_bytes = lvl_t'(BUF_BYTES) - level_q;
  assign mem_req    = (state_q == S_RUN) && (words_fetched_q < words_tgt_q) &&
                      (free_bytes >= lvl_t'(MEM_BYTES));
  assign push       = mem_req && mem_data_valid;
  assign pop        = (state_q == S_RUN) && (groups_sent_q < groups_tgt_q) &&
                      (level_q >= need) && (!out_valid_q || out_ready);
  assign last_xfer  = (state_q == S_RUN) && out_valid_q && out_ready &&
                      (groups_sent_q == groups_tgt_q);
  assign starve     = (state_q == S_RUN) && (words_fetched_q == words_tgt_q) &&
                      (level_q < need) && !out_valid_q && (groups_sent_q < groups_tgt_q);

  always_comb begin : next_state
    state_d         = state_q;
    raw_d           = raw_q;
    groups_tgt_d    = groups_tgt_q;
    words_tgt_d     = words_tgt_q;
    groups_sent_d   = groups_sent_q;
    words_fetched_d = words_fetched_q;
    buf_d           = buf_q;
    head_d          = head_q;
    tail_d          = tail_q;
    level_d         = level_q + (push ? lvl_t'(MEM_BYTES) : '0) - (pop ? need : '0);
    out_valid_d     = out_valid_q && !out_ready;
    out_data_d      = out_data_q;
    out_mask_d      = out_mask_q;
    done_d          = 1'b0;
    err_d           = err_q;

    if (push) begin
      for (int k = 0; k < MEM_BYTES; k++) begin
        buf_d[wrap_add(tail_q, k)] = mem_data[8*k +: 8];
      end
      tail_d          = wrap_add(tail_q, MEM_BYTES);
      words_fetched_d = words_fetched_q + CNT_ONE;
    end

    if (pop) begin
      head_d        = wrap_add(head_q, int'(need));
      groups_sent_d = groups_sent_q + CNT_ONE;
      out_valid_d   = 1'b1;
      out_data_d    = dense;
      out_mask_d    = dense_mask;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          raw_d           = raw_mode;
          groups_tgt_d    = group_count;
          words_tgt_d     = word_count;
          groups_sent_d   = '0;
          words_fetched_d = '0;
          err_d           = 1'b0;
          state_d         = (group_count == '0) ? S_FINISH : S_RUN;
        end
      end
      S_RUN: begin
        if (last_xfer) begin
          state_d = S_FINISH;
        end else if (starve) begin
          state_d = S_FINISH;
          err_d   = 1'b1;
        end
      end
      S_FINISH: begin
        done_d  = 1'b1;
        head_d  = '0;
        tail_d  = '0;
        level_d = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= S_IDLE;
      raw_q           <= 1'b0;
      groups_tgt_q    <= '0;
      words_tgt_q     <= '0;
      groups_sent_q   <= '0;
      words_fetched_q <= '0;
      for (int i = 0; i < BUF_BYTES; i++) buf_q[i] <= '0;
      head_q          <= '0;
      tail_q          <= '0;
      level_q         <= '0;
      out_valid_q     <= 1'b0;
      out_data_q      <= '0;
      out_mask_q      <= '0;
      done_q          <= 1'b0;
      err_q           <= 1'b0;
    end else begin
      state_q         <= state_d;
      raw_q           <= raw_d;
      groups_tgt_q    <= groups_tgt_d;
      words_tgt_q     <= words_tgt_d;
      groups_sent_q   <= groups_sent_d;
      words_fetched_q <= words_fetched_d;
      buf_q           <= buf_d;
      head_q          <= head_d;
      tail_q          <= tail_d;
      level_q         <= level_d;
      out_valid_q     <= out_valid_d;
      out_data_q      <= out_data_d;
      out_mask_q      <= out_mask_d;
      done_q          <= done_d;
      err_q           <= err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_mask  = out_mask_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_sparse_stream_decompressor.sv
// tb/tb_sparse_stream_decompressor.sv - scoreboard bench for sparse_stream_decompressor
// Expected groups come from a byte-stream parse model; a negedge monitor pops and compares.
module tb_sparse_stream_decompressor;

  localparam int MEM_BYTES = 16;
  localparam int LANES     = 8;
  localparam int CNT_W     = 16;

  typedef struct packed {
    logic [LANES*8-1:0] data;
    logic [LANES-1:0]   mask;
  } grp_t;
  typedef logic [7:0] byte_q_t [$];

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   start = 1'b0;
  logic                   raw_mode = 1'b0;
  logic [CNT_W-1:0]       group_count = '0;
  logic [CNT_W-1:0]       word_count = '0;
  logic                   mem_req;
  logic [MEM_BYTES*8-1:0] mem_data = '0;
  logic                   mem_data_valid = 1'b0;
  logic                   out_valid;
  logic                   out_ready = 1'b1;
  logic [LANES*8-1:0]     out_data;
  logic [LANES-1:0]       out_mask;
  logic                   done;
  logic                   err;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  grp_t exp_q[$];
  logic [MEM_BYTES*8-1:0] mem_q[$];
  int xfer_cycle[$];
  bit mem_gaps = 0;
  bit ready_rand = 0;
  int ready_hold = 0;

  sparse_stream_decompressor #(
    .MEM_BYTES(MEM_BYTES), .LANES(LANES), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .raw_mode(raw_mode),
    .group_count(group_count), .word_count(word_count),
    .mem_req(mem_req), .mem_data(mem_data), .mem_data_valid(mem_data_valid),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_mask(out_mask), .done(done), .err(err)
  );

  initial forever #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: walk the fetched byte stream group by group.
  function automatic bit model(input bit raw, input int gc, input byte_q_t bs);
    int pos = 0;
    int k;
    grp_t g;
    logic [7:0] m;
    for (int gi = 0; gi < gc; gi++) begin
      g = '0;
      if (raw) begin
        if (pos + LANES > bs.size()) return 1'b1;
        for (int l = 0; l < LANES; l++) g.data[8*l +: 8] = bs[pos + l];
        g.mask = '1;
        pos += LANES;
      end else begin
        if (pos + 1 > bs.size()) return 1'b1;
        m = bs[pos];
        if (pos + 1 + $countones(m) > bs.size()) return 1'b1;
        k = pos + 1;
        for (int l = 0; l < LANES; l++) begin
          if (m[l]) begin
            g.data[8*l +: 8] = bs[k];
            k++;
          end
        end
        g.mask = m;
        pos = k;
      end
      exp_q.push_back(g);
    end
    return 1'b0;
  endfunction

  initial forever begin
    @(negedge clk);
    if (mem_req && mem_data_valid && mem_q.size() > 0) mem_q.delete(0);
    @(posedge clk);
    #1;
    if (mem_q.size() > 0 && (!mem_gaps || $urandom_range(0, 3) != 0)) begin
      mem_data = mem_q[0];
      mem_data_valid = 1'b1;
    end else begin
      mem_data = {4{$urandom()}};
      mem_data_valid = 1'b0;
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (ready_hold > 0) begin
      out_ready = 1'b0;
      ready_hold--;
    end else begin
      out_ready = ready_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
    end
  end

  initial begin : monitor
    grp_t prev;
    grp_t e;
    bit prev_stall;
    prev = '0;
    prev_stall = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 0;
      end else begin
        if (prev_stall) begin
          check("hold_valid", out_valid, 1'b1);
          check("hold_data", {out_data, out_mask}, prev);
        end
        if (out_valid && out_ready) begin
          xfer_cycle.push_back(cyc);
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_group: got %h expected none", {out_data, out_mask});
          end else begin
            e = exp_q.pop_front();
            check("group", {out_data, out_mask}, e);
          end
        end
        prev_stall = out_valid && !out_ready;
        prev = {out_data, out_mask};
      end
    end
  end

  task automatic start_job(input bit raw, input int gc, input byte_q_t bs, output bit e_err);
    logic [MEM_BYTES*8-1:0] wd;
    mem_q.delete();
    for (int w = 0; w < bs.size() / MEM_BYTES; w++) begin
      for (int k = 0; k < MEM_BYTES; k++) wd[8*k +: 8] = bs[MEM_BYTES*w + k];
      mem_q.push_back(wd);
    end
    e_err = model(raw, gc, bs);
    @(posedge clk);
    #1;
    raw_mode = raw;
    group_count = CNT_W'(gc);
    word_count = CNT_W'(bs.size() / MEM_BYTES);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    raw_mode = ~raw;
    group_count = CNT_W'($urandom_range(0, 50));
    word_count = CNT_W'($urandom_range(0, 50));
  endtask

  task automatic wait_done(input string tag, input bit exp_err, input bit restart_mid,
                           output int n, output bit saw_req);
    n = 0;
    saw_req = 0;
    @(negedge clk);
    n = 1;
    saw_req = mem_req;
    check({tag, "_err_clear"}, err, 1'b0);
    while (!done && n < 3000) begin
      if (restart_mid && n == 3) begin
        start = 1'b1;
        raw_mode = $urandom_range(0, 1);
        group_count = 1;
        word_count = 1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      n++;
      if (mem_req) saw_req = 1;
    end
    start = 1'b0;
    if (!done) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: got no done expected done within 3000 cycles", tag);
    end else begin
      check({tag, "_err"}, err, exp_err);
      check({tag, "_left"}, exp_q.size(), 0);
      @(negedge clk);
      check({tag, "_done_pulse"}, done, 1'b0);
    end
  endtask

  task automatic run_job(input string tag, input bit raw, input int gc, input byte_q_t bs,
                         input bit restart_mid, output int n, output bit saw_req);
    bit e_err;
    start_job(raw, gc, bs, e_err);
    wait_done(tag, e_err, restart_mid, n, saw_req);
  endtask

  function automatic byte_q_t case2_stream();
    byte_q_t bs;
    bs = {8'hA5, 8'h11, 8'h22, 8'h33, 8'h44, 8'h00, 8'hFF,
          8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'hEE};
    return bs;
  endfunction

  function automatic byte_q_t rand_stream(input bit raw, input int ngen, input bit short);
    byte_q_t bs;
    logic [7:0] m;
    for (int g = 0; g < ngen; g++) begin
      if (raw) begin
        for (int l = 0; l < LANES; l++) bs.push_back(8'($urandom()));
      end else begin
        case ($urandom_range(0, 5))
          0: m = 8'h00;
          1: m = 8'hFF;
          default: m = 8'($urandom());
        endcase
        bs.push_back(m);
        for (int l = 0; l < $countones(m); l++) bs.push_back(8'($urandom_range(1, 255)));
      end
    end
    while (bs.size() % MEM_BYTES != 0) bs.push_back(8'($urandom()));
    if (short && bs.size() > MEM_BYTES) begin
      for (int k = 0; k < MEM_BYTES; k++) void'(bs.pop_back());
    end
    return bs;
  endfunction

  initial begin : main
    byte_q_t bs;
    bit e_err;
    bit raw;
    bit req;
    int n;
    int ngen;
    int gc;

    repeat (3) @(negedge clk);
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_out_data", out_data, 64'h0);
    check("rst_out_mask", out_mask, 8'h00);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    run_job("case2", 0, 3, case2_stream(), 0, n, req);

    bs.delete();
    for (int i = 0; i < 32; i++) bs.push_back(8'(i));
    xfer_cycle.delete();
    run_job("raw", 1, 4, bs, 0, n, req);
    check("raw_count", xfer_cycle.size(), 4);
    if (xfer_cycle.size() == 4) check("raw_b2b", xfer_cycle[3] - xfer_cycle[0], 3);

    ready_hold = 5;
    run_job("bp_case2", 0, 3, case2_stream(), 0, n, req);

    bs = rand_stream(1, 10, 0);
    ready_hold = 14;
    start_job(1, 10, bs, e_err);
    repeat (8) @(negedge clk);
    check("full_mem_req", mem_req, 1'b0);
    check("full_out_valid", out_valid, 1'b1);
    wait_done("bp_full", e_err, 0, n, req);

    bs = rand_stream(1, 2, 0);
    run_job("starve", 1, 5, bs, 0, n, req);

    bs.delete();
    run_job("zero", 0, 0, bs, 0, n, req);
    check("zero_done_lat", n, 2);
    check("zero_no_req", req, 1'b0);

    bs = rand_stream(0, 6, 0);
    run_job("restart", 0, 6, bs, 1, n, req);

    ready_rand = 1;
    mem_gaps = 1;
    for (int t = 0; t < 24; t++) begin
      raw = $urandom_range(0, 1);
      ngen = $urandom_range(1, 10);
      gc = ($urandom_range(0, 4) == 0) ? ngen + 2 : $urandom_range(1, ngen);
      bs = rand_stream(raw, ngen, $urandom_range(0, 3) == 0);
      run_job("rand", raw, gc, bs, 0, n, req);
    end
    ready_rand = 0;
    mem_gaps = 0;

    bs = rand_stream(1, 10, 0);
    ready_hold = 30;
    start_job(1, 10, bs, e_err);
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("rst_mid_valid_seen", out_valid, 1'b1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_mem_req", mem_req, 1'b0);
    check("async_out_valid", out_valid, 1'b0);
    check("async_done", done, 1'b0);
    check("async_err", err, 1'b0);
    check("async_out_data", out_data, 64'h0);
    exp_q.delete();
    mem_q.delete();
    ready_hold = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_mem_req", mem_req, 1'b0);
    check("post_rst_out_valid", out_valid, 1'b0);
    run_job("after_rst", 0, 3, case2_stream(), 0, n, req);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
